bft_leaf_inject_queue: RTL and testbench

- Sits between a leaf's packet creator and that leaf's BFT network port.
- Captures valid packets from the creator into a small FIFO and back-pressures the creator via its resend input.
- Presents packets one at a time to the network and retransmits on network resend, with a fixed backoff.
- Guarantees in-order, lossless delivery as long as the source honours back-pressure.

---
 rtl/bft_pkg.sv | 25 ++
 rtl/bft_leaf_inject_queue_if.sv | 30 +++
 rtl/bft_sync_fifo.sv | 44 ++++
 rtl/bft_leaf_inject_queue.sv | 107 ++++++++++
 tb/tb_bft_leaf_inject_queue.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bft_pkg.sv
// Shared definitions for the BFT leaf inject queue: packet geometry helpers and FSM encoding.
package bft_pkg;

    function automatic int pkt_width(input int num_leaves, input int payload_sz);
        return 1 + $clog2(num_leaves) + payload_sz;
    endfunction

    // Packet layout is {valid, dest_addr, payload}; payload starts at bit 0.
    function automatic int valid_bit(input int p_sz);
        return p_sz - 1;
    endfunction

    function automatic int addr_lsb(input int payload_sz);
        return payload_sz;
    endfunction

    localparam int PAYLOAD_LSB = 0;

    localparam int STATE_W = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_BACKOFF = 2'd3;

endpackage

// File: rtl/bft_leaf_inject_queue_if.sv
// Creator/network-side signal bundle for the leaf inject queue, plus FSM state for observation.
interface bft_leaf_inject_queue_if #(
    parameter int P_SZ  = 3,
    parameter int CNT_W = 4
);
    import bft_pkg::*;

    // Handshake: a packet is offered when pkt_i[MSB]=1; the creator must hold its next packet
    // while resend_o=1. The network rejects the packet shown on net_o by raising net_resend_i
    // in the following cycle; no rejection in that cycle means the packet was taken.
    logic [P_SZ-1:0]    pkt_i;
    logic               resend_o;
    logic [P_SZ-1:0]    net_o;
    logic               net_resend_i;
    logic [CNT_W-1:0]   count_o;
    logic               drop_o;
    logic [15:0]        retry_cnt_o;
    logic [STATE_W-1:0] state_o;

    modport slave (
        input  pkt_i, net_resend_i,
        output resend_o, net_o, count_o, drop_o, retry_cnt_o, state_o
    );

    modport master (
        output pkt_i, net_resend_i,
        input  resend_o, net_o, count_o, drop_o, retry_cnt_o, state_o
    );

endinterface

// File: rtl/bft_sync_fifo.sv
// Single-clock FIFO with registered occupancy; exposes the head and the entry that follows it.
module bft_sync_fifo #(
    parameter int width = 3,
    parameter int depth = 8,
    localparam int AW = $clog2(depth),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] head,
    output logic [width-1:0] next_head,
    output logic [CW-1:0]    count
);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;

    assign rd_ptr_nxt = rd_ptr + 1'b1;
    assign head       = mem[rd_ptr];
    // After a pop the new head is the second entry, or the word being written if only one remains.
    assign next_head  = (count > CW'(1)) ? mem[rd_ptr_nxt] : wr_data;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr_nxt;
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/bft_leaf_inject_queue.sv
// Buffers creator packets and feeds them one at a time to the BFT port, retrying with backoff on rejection.
module bft_leaf_inject_queue
    import bft_pkg::*;
#(
    parameter int num_leaves = 2,
    parameter int payload_sz = 1,
    parameter int p_sz       = pkt_width(num_leaves, payload_sz),
    parameter int depth      = 8,
    parameter int backoff    = 2,
    localparam int CW   = $clog2(depth) + 1,
    localparam int VB   = valid_bit(p_sz),
    localparam int BO_W = (backoff > 1) ? $clog2(backoff) : 1
) (
    input  logic clk,
    input  logic reset,
    bft_leaf_inject_queue_if.slave bus
);

    logic [STATE_W-1:0] state;
    logic [p_sz-1:0]    net;
    logic [p_sz-1:0]    head;
    logic [p_sz-1:0]    next_head;
    logic [CW-1:0]      count;
    logic [BO_W-1:0]    bo_cnt;
    logic [15:0]        retry_cnt;
    logic               drop;
    logic               push;
    logic               pop;
    logic               full;

    assign full = (count == CW'(depth));
    // A same-cycle pop does not free a slot: full is judged on the registered count.
    assign push = bus.pkt_i[VB] && !full;
    assign pop  = (state == ST_CHECK) && !bus.net_resend_i;

    bft_sync_fifo #(
        .width (p_sz),
        .depth (depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (push),
        .wr_data   (bus.pkt_i),
        .rd_en     (pop),
        .head      (head),
        .next_head (next_head),
        .count     (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            net       <= '0;
            bo_cnt    <= '0;
            retry_cnt <= '0;
            drop      <= 1'b0;
        end else begin
            drop <= bus.pkt_i[VB] && full;
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state <= ST_SEND;
                        net   <= head;
                    end
                end
                ST_SEND: begin
                    state <= ST_CHECK;
                    net   <= '0;
                end
                ST_CHECK: begin
                    if (bus.net_resend_i) begin
                        if (retry_cnt != 16'hFFFF) retry_cnt <= retry_cnt + 16'd1;
                        if (backoff == 0) begin
                            state <= ST_SEND;
                            net   <= head;
                        end else begin
                            state  <= ST_BACKOFF;
                            bo_cnt <= BO_W'(backoff - 1);
                        end
                    end else if ((count > CW'(1)) || push) begin
                        state <= ST_SEND;
                        net   <= next_head;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BACKOFF: begin
                    if (bo_cnt == '0) begin
                        state <= ST_SEND;
                        net   <= head;
                    end else begin
                        bo_cnt <= bo_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.net_o       = net;
    assign bus.count_o     = count;
    assign bus.resend_o    = (count >= CW'(depth - 1));
    assign bus.drop_o      = drop;
    assign bus.retry_cnt_o = retry_cnt;
    assign bus.state_o     = state;

endmodule

// File: tb/tb_bft_leaf_inject_queue.sv
// Scenario bench for bft_leaf_inject_queue with a packet scoreboard for delivery order.
module tb_bft_leaf_inject_queue;
    import bft_pkg::*;

    localparam int P_SZ  = 3;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [P_SZ-1:0] exp_q[$];

    always #5 clk = ~clk;

    bft_leaf_inject_queue_if #(.P_SZ(P_SZ), .CNT_W(CNT_W)) bus ();

    bft_leaf_inject_queue #(
        .num_leaves (2),
        .payload_sz (1),
        .p_sz       (P_SZ),
        .depth      (DEPTH),
        .backoff    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic do_reset();
        bus.pkt_i        = '0;
        bus.net_resend_i = 1'b0;
        reset            = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.pkt_i        = '0;
        bus.net_resend_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.net_o !== 3'b000) begin errors++; $display("FAIL reset_net_o: got %b expected 000", bus.net_o); end
        checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL reset_count_o: got %0d expected 0", bus.count_o); end
        checks++; if (bus.resend_o !== 1'b0) begin errors++; $display("FAIL reset_resend_o: got %b expected 0", bus.resend_o); end
        checks++; if (bus.drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop_o: got %b expected 0", bus.drop_o); end
        checks++; if (bus.retry_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_retry_cnt_o: got %0d expected 0", bus.retry_cnt_o); end
        checks++; if (bus.state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.state_o, ST_IDLE); end
    endtask

    task automatic test_single();
        logic [P_SZ-1:0] exp_net;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_net = (c == 2) ? 3'b110 : 3'b000;
            checks++;
            if (bus.net_o !== exp_net) begin errors++; $display("FAIL single_net_o c%0d: got %b expected %b", c, bus.net_o, exp_net); end
            if (c >= 4) begin
                checks++;
                if (bus.count_o !== 4'd0) begin errors++; $display("FAIL single_count_o c%0d: got %0d expected 0", c, bus.count_o); end
            end
            bus.pkt_i = (c == 0) ? 3'b110 : 3'b000;
        end
        checks++; if (bus.state_o !== ST_IDLE) begin errors++; $display("FAIL single_state: got %0d expected %0d", bus.state_o, ST_IDLE); end
    endtask

    task automatic test_reject();
        logic [P_SZ-1:0] exp_net;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_net = (c == 2 || c == 6) ? 3'b110 : 3'b000;
            checks++;
            if (bus.net_o !== exp_net) begin errors++; $display("FAIL reject_net_o c%0d: got %b expected %b", c, bus.net_o, exp_net); end
            if (c == 8) begin
                checks++;
                if (bus.count_o !== 4'd0) begin errors++; $display("FAIL reject_count_o: got %0d expected 0", bus.count_o); end
            end
            bus.pkt_i        = (c == 0) ? 3'b110 : 3'b000;
            bus.net_resend_i = (c == 3);
        end
        checks++; if (bus.retry_cnt_o !== 16'd1) begin errors++; $display("FAIL reject_retry_cnt_o: got %0d expected 1", bus.retry_cnt_o); end
    endtask

    task automatic test_fill();
        int   exp_cnt;
        logic exp_drop;
        exp_cnt  = 0;
        exp_drop = 1'b0;
        do_reset();
        bus.net_resend_i = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            checks++;
            if (bus.count_o !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL fill_count_o c%0d: got %0d expected %0d", c, bus.count_o, exp_cnt); end
            checks++;
            if (bus.resend_o !== (exp_cnt >= DEPTH - 1)) begin errors++; $display("FAIL fill_resend_o c%0d: got %b expected %b", c, bus.resend_o, (exp_cnt >= DEPTH - 1)); end
            checks++;
            if (bus.drop_o !== exp_drop) begin errors++; $display("FAIL fill_drop_o c%0d: got %b expected %b", c, bus.drop_o, exp_drop); end
            bus.pkt_i = (c <= 8) ? 3'b100 : 3'b000;
            exp_drop  = (c <= 8) && (exp_cnt == DEPTH);
            if (c <= 8 && exp_cnt < DEPTH) exp_cnt++;
        end
        bus.net_resend_i = 1'b0;
    endtask

    task automatic test_push_pop();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (bus.net_o !== 3'b110) begin errors++; $display("FAIL pushpop_first_net_o: got %b expected 110", bus.net_o); end
            end
            if (c == 3) begin
                checks++;
                if (bus.state_o !== ST_CHECK) begin errors++; $display("FAIL pushpop_in_check: got %0d expected %0d", bus.state_o, ST_CHECK); end
                checks++;
                if (bus.count_o !== 4'd1) begin errors++; $display("FAIL pushpop_count_before: got %0d expected 1", bus.count_o); end
            end
            if (c == 4) begin
                checks++;
                if (bus.count_o !== 4'd1) begin errors++; $display("FAIL pushpop_count_after: got %0d expected 1", bus.count_o); end
                checks++;
                if (bus.state_o !== ST_SEND) begin errors++; $display("FAIL pushpop_state: got %0d expected %0d", bus.state_o, ST_SEND); end
                checks++;
                if (bus.net_o !== 3'b111) begin errors++; $display("FAIL pushpop_net_o: got %b expected 111", bus.net_o); end
            end
            if (c == 6) begin
                checks++;
                if (bus.count_o !== 4'd0) begin errors++; $display("FAIL pushpop_drain: got %0d expected 0", bus.count_o); end
            end
            bus.pkt_i        = (c == 0) ? 3'b110 : ((c == 3) ? 3'b111 : 3'b000);
            bus.net_resend_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.net_resend_i = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            bus.pkt_i = (c < 7) ? 3'b110 : 3'b000;
        end
        checks++; if (bus.net_o !== 3'b110) begin errors++; $display("FAIL midreset_pre_net_o: got %b expected 110", bus.net_o); end
        checks++; if (bus.resend_o !== 1'b1) begin errors++; $display("FAIL midreset_pre_resend_o: got %b expected 1", bus.resend_o); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.net_o !== 3'b000) begin errors++; $display("FAIL midreset_net_o: got %b expected 000", bus.net_o); end
        checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL midreset_count_o: got %0d expected 0", bus.count_o); end
        checks++; if (bus.resend_o !== 1'b0) begin errors++; $display("FAIL midreset_resend_o: got %b expected 0", bus.resend_o); end
        @(negedge clk);
        reset            = 1'b1;
        bus.net_resend_i = 1'b0;
        bus.pkt_i        = 3'b011;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.pkt_i = 3'b000;
            checks++;
            if (bus.count_o !== 4'd0) begin errors++; $display("FAIL midreset_ignore_count c%0d: got %0d expected 0", c, bus.count_o); end
            checks++;
            if (bus.net_o !== 3'b000) begin errors++; $display("FAIL midreset_ignore_net c%0d: got %b expected 000", c, bus.net_o); end
        end
        exp_q.delete();
    endtask

    task automatic test_ordering();
        logic [P_SZ-1:0] pkts [6];
        int   rejects;
        int   delivered;
        int   cyc;
        logic sent_prev;
        pkts      = '{3'b101, 3'b110, 3'b100, 3'b111, 3'b101, 3'b110};
        rejects   = 0;
        delivered = 0;
        cyc       = 0;
        sent_prev = 1'b0;
        do_reset();
        while (delivered < 6 && cyc < 1000) begin
            @(negedge clk);
            if (bus.net_o !== 3'b000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL order_unexpected: got %b expected no packet", bus.net_o);
                end else if (bus.net_o !== exp_q[0]) begin
                    errors++; $display("FAIL order_net_o: got %b expected %b", bus.net_o, exp_q[0]);
                end
            end
            bus.pkt_i = (cyc < 6) ? pkts[cyc] : 3'b000;
            if (cyc < 6) exp_q.push_back(pkts[cyc]);
            bus.net_resend_i = 1'($urandom_range(0, 1));
            if (sent_prev) begin
                if (bus.net_resend_i) rejects++;
                else begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    delivered++;
                end
            end
            sent_prev = (bus.net_o !== 3'b000);
            cyc++;
        end
        @(negedge clk);
        bus.net_resend_i = 1'b0;
        checks++; if (delivered != 6) begin errors++; $display("FAIL order_timeout: got %0d delivered expected 6", delivered); end
        checks++; if (bus.retry_cnt_o !== 16'(rejects)) begin errors++; $display("FAIL order_retry_cnt_o: got %0d expected %0d", bus.retry_cnt_o, rejects); end
        checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL order_count_o: got %0d expected 0", bus.count_o); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL order_leftover: got %0d queued expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reject();
        test_fill();
        test_push_pop();
        test_reset_mid();
        test_ordering();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
